// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - decodes a scanned active-low 7-segment bus back into per-position digit values
// Define SEG_DECODE_HEX_EN to also decode the A-F glyphs as values 10-15.
module seg_scan_decoder #(
  parameter int         NUM_DIGITS    = 8,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] SCAN_MASK     = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              anode,
  input  logic [7:0]              cathode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    frame_done,
  output logic                    bad_pattern
);
  localparam int            CW         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP    = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    POS_MASK   = 8'((9'd1 << NUM_DIGITS) - 9'd1);
  localparam logic [7:0]    FRAME_MASK = SCAN_MASK & POS_MASK;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state, state_next;

  logic [7:0]    anode_q, cathode_q, seen, seen_next, sel;
  logic [CW-1:0] dwell;
  logic [4:0]    dec;
  logic          changed, capture, blank, frame_hit;

  // A lit anode outside the decoded range makes the bus count as not one-hot.
  function automatic logic one_hot(input logic [7:0] a);
    logic [7:0] lit;
    lit = ~a & POS_MASK;
    return (lit != 8'h00) && ((lit & (lit - 8'h01)) == 8'h00) && ((~a & ~POS_MASK) == 8'h00);
  endfunction

  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
`ifdef SEG_DECODE_HEX_EN
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
`endif
      default: decode = 5'h00;
    endcase
  endfunction

  // The incoming pair is compared against the registered one, so a pair must be
  // registered on SETTLE_CYCLES+1 consecutive edges before it is captured.
  assign changed   = {anode, cathode} != {anode_q, cathode_q};
  assign sel       = ~anode_q & POS_MASK;
  assign dec       = decode(cathode_q[6:0]);
  assign blank     = cathode_q[6:0] == 7'h7F;
  assign seen_next = seen | sel;
  assign frame_hit = (FRAME_MASK != 8'h00) && ((seen_next & FRAME_MASK) == FRAME_MASK);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      SETTLE: begin
        if (changed) begin
          state_next = one_hot(anode) ? SETTLE : IDLE;
        end else if (dwell >= CNT_CAP) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      default: begin
        if (changed) state_next = one_hot(anode) ? SETTLE : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      anode_q     <= 8'hFF;
      cathode_q   <= 8'hFF;
      dwell       <= '0;
      seen        <= '0;
      digits      <= '0;
      digit_valid <= '0;
      dp          <= '0;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      state      <= state_next;
      anode_q    <= anode;
      cathode_q  <= cathode;
      frame_done <= 1'b0;
      if (changed) dwell <= '0;
      else if (dwell != CNT_MAX) dwell <= dwell + CW'(1);
      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            if (dec[4]) digits[4*i +: 4] <= dec[3:0];
            digit_valid[i] <= dec[4];
            dp[i]          <= ~cathode_q[7];
          end
        end
        if (!dec[4] && !blank) bad_pattern <= 1'b1;
        if (frame_hit) begin
          seen       <= '0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end
endmodule
